sd_sector_responder: RTL and testbench



---
 rtl/sd_resp_pkg.sv | 19 +
 rtl/sd_sector_responder.sv | 194 +++++++++++++++++++
 tb/tb_sd_sector_responder.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_resp_pkg.sv
// Shared types and constants for the sector responder: FSM state encoding and sector geometry.
package sd_resp_pkg;

  localparam int unsigned SECT_BYTES = 512;
  localparam int unsigned IDX_W      = 9;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SECT_BYTES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StRdReq,
    StRdPush,
    StWrAddr,
    StWrCapt,
    StWrReq,
    StDone
  } sd_resp_state_t;

endpackage

// File: rtl/sd_sector_responder.sv
// Target-side server for the 512-byte sd_lba/sd_rd/sd_wr/sd_ack sector handshake, backed by a
// byte-wide store. Optional write protect (wr_prot/wp_hit) when SD_RESP_WRPROT_EN is defined.
module sd_sector_responder
  import sd_resp_pkg::*;
#(
  parameter int unsigned BLK_BITS    = 8,
  parameter int unsigned START_DELAY = 4
) (
  input  logic                      clk_sys,
  input  logic                      RESET_n,
  input  logic [31:0]               sd_lba,
  input  logic                      sd_rd,
  input  logic                      sd_wr,
  output logic                      sd_ack,
  output logic [IDX_W-1:0]          sd_buff_addr,
  output logic [7:0]                sd_buff_dout,
  output logic                      sd_buff_wr,
  input  logic [7:0]                sd_buff_din,
`ifdef SD_RESP_WRPROT_EN
  input  logic                      wr_prot,
  output logic                      wp_hit,
`endif
  output logic [BLK_BITS+IDX_W-1:0] mem_addr,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [7:0]                mem_wdata,
  input  logic [7:0]                mem_rdata,
  input  logic                      mem_ack,
  output logic                      busy,
  output logic [15:0]               sect_cnt
);

  localparam int unsigned DCNT_W = (START_DELAY < 1) ? 1 : $clog2(START_DELAY + 1);

  sd_resp_state_t      r_state, w_state_d;
  logic [BLK_BITS-1:0] r_lba, w_lba_d;
  logic                r_is_wr, w_is_wr_d;
  logic                r_prot, w_prot_d;
  logic [IDX_W-1:0]    r_idx, w_idx_d;
  logic [IDX_W-1:0]    r_addr, w_addr_d;
  logic [DCNT_W-1:0]   r_dcnt, w_dcnt_d;
  logic                r_sd_ack, w_sd_ack_d;
  logic [7:0]          r_dout, w_dout_d;
  logic [7:0]          r_wdata, w_wdata_d;
  logic [15:0]         r_sect_cnt, w_sect_cnt_d;

  logic w_last;
  logic w_wr_done;
  logic w_wr_prot_req;
  logic w_lba_unused;

  // Upper LBA bits are ignored so the store aliases.
  assign w_lba_unused = ^sd_lba[31:BLK_BITS];

`ifdef SD_RESP_WRPROT_EN
  logic r_wp_hit;

  assign w_wr_prot_req = wr_prot;
  assign wp_hit        = r_wp_hit;

  always_ff @(posedge clk_sys) begin
    if (!RESET_n) begin
      r_wp_hit <= 1'b0;
    end else if (r_state == StIdle && !sd_rd && sd_wr && wr_prot) begin
      r_wp_hit <= 1'b1;
    end
  end
`else
  assign w_wr_prot_req = 1'b0;
`endif

  assign w_last = (r_idx == IDX_LAST);
  // A protected write skips the store, so its WR_REQ completes without waiting for mem_ack.
  assign w_wr_done = r_prot | mem_ack;

  always_ff @(posedge clk_sys) begin
    if (!RESET_n) begin
      r_state    <= StIdle;
      r_lba      <= '0;
      r_is_wr    <= 1'b0;
      r_prot     <= 1'b0;
      r_idx      <= '0;
      r_addr     <= '0;
      r_dcnt     <= '0;
      r_sd_ack   <= 1'b0;
      r_dout     <= '0;
      r_wdata    <= '0;
      r_sect_cnt <= '0;
    end else begin
      r_state    <= w_state_d;
      r_lba      <= w_lba_d;
      r_is_wr    <= w_is_wr_d;
      r_prot     <= w_prot_d;
      r_idx      <= w_idx_d;
      r_addr     <= w_addr_d;
      r_dcnt     <= w_dcnt_d;
      r_sd_ack   <= w_sd_ack_d;
      r_dout     <= w_dout_d;
      r_wdata    <= w_wdata_d;
      r_sect_cnt <= w_sect_cnt_d;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_lba_d      = r_lba;
    w_is_wr_d    = r_is_wr;
    w_prot_d     = r_prot;
    w_idx_d      = r_idx;
    w_addr_d     = r_addr;
    w_dcnt_d     = r_dcnt;
    w_sd_ack_d   = r_sd_ack;
    w_dout_d     = r_dout;
    w_wdata_d    = r_wdata;
    w_sect_cnt_d = r_sect_cnt;

    unique case (r_state)
      StIdle: begin
        if (sd_rd || sd_wr) begin
          w_lba_d   = sd_lba[BLK_BITS-1:0];
          w_is_wr_d = ~sd_rd;
          w_prot_d  = ~sd_rd & w_wr_prot_req;
          w_idx_d   = '0;
          w_dcnt_d  = '0;
          w_state_d = StStart;
        end
      end
      StStart: begin
        if (r_dcnt == DCNT_W'(START_DELAY)) begin
          w_sd_ack_d = 1'b1;
          if (r_is_wr) begin
            w_addr_d  = r_idx;
            w_state_d = StWrAddr;
          end else begin
            w_state_d = StRdReq;
          end
        end else begin
          w_dcnt_d = r_dcnt + DCNT_W'(1);
        end
      end
      StRdReq: begin
        if (mem_ack) begin
          w_dout_d  = mem_rdata;
          w_addr_d  = r_idx;
          w_state_d = StRdPush;
        end
      end
      StRdPush: begin
        if (w_last) begin
          w_sd_ack_d = 1'b0;
          w_state_d  = StDone;
        end else begin
          w_idx_d   = r_idx + IDX_W'(1);
          w_state_d = StRdReq;
        end
      end
      StWrAddr: w_state_d = StWrCapt;
      StWrCapt: begin
        // The core RAM has registered the address one edge ago; its data is valid now.
        w_wdata_d = sd_buff_din;
        w_state_d = StWrReq;
      end
      StWrReq: begin
        if (w_wr_done) begin
          if (w_last) begin
            w_sd_ack_d = 1'b0;
            w_state_d  = StDone;
          end else begin
            w_idx_d   = r_idx + IDX_W'(1);
            w_addr_d  = r_idx + IDX_W'(1);
            w_state_d = StWrAddr;
          end
        end
      end
      StDone: begin
        w_sect_cnt_d = r_sect_cnt + 16'd1;
        w_state_d    = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign sd_ack       = r_sd_ack;
  assign sd_buff_addr = r_addr;
  assign sd_buff_dout = r_dout;
  assign sd_buff_wr   = (r_state == StRdPush);
  assign mem_addr     = {r_lba, r_idx};
  assign mem_req      = (r_state == StRdReq) | ((r_state == StWrReq) & ~r_prot);
  assign mem_we       = (r_state == StWrReq) & ~r_prot;
  assign mem_wdata    = r_wdata;
  assign busy         = (r_state != StIdle);
  assign sect_cnt     = r_sect_cnt;

endmodule

// File: tb/tb_sd_sector_responder.sv
// Bench for sd_sector_responder: behavioural core RAM and backing store with random ack delay,
// a byte-array reference of the store, table-driven sector vectors and multi-cycle sequences.
module tb_sd_sector_responder;

  localparam int BLK         = 8;
  localparam int SDLY        = 4;
  localparam int STORE_BYTES = 512 << BLK;

  logic              clk;
  logic              RESET_n;
  logic [31:0]       sd_lba;
  logic              sd_rd;
  logic              sd_wr;
  logic              sd_ack;
  logic [8:0]        sd_buff_addr;
  logic [7:0]        sd_buff_dout;
  logic              sd_buff_wr;
  logic [7:0]        sd_buff_din;
  logic [BLK+8:0]    mem_addr;
  logic              mem_req;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_ack;
  logic              busy;
  logic [15:0]       sect_cnt;
`ifdef SD_RESP_WRPROT_EN
  logic              wr_prot;
  logic              wp_hit;
`endif

  sd_sector_responder #(
    .BLK_BITS   (BLK),
    .START_DELAY(SDLY)
  ) u_dut (
    .clk_sys     (clk),
    .RESET_n     (RESET_n),
    .sd_lba      (sd_lba),
    .sd_rd       (sd_rd),
    .sd_wr       (sd_wr),
    .sd_ack      (sd_ack),
    .sd_buff_addr(sd_buff_addr),
    .sd_buff_dout(sd_buff_dout),
    .sd_buff_wr  (sd_buff_wr),
    .sd_buff_din (sd_buff_din),
`ifdef SD_RESP_WRPROT_EN
    .wr_prot     (wr_prot),
    .wp_hit      (wp_hit),
`endif
    .mem_addr    (mem_addr),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .busy        (busy),
    .sect_cnt    (sect_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [7:0] store   [STORE_BYTES];
  logic [7:0] ref_mem [STORE_BYTES];
  logic [7:0] core_ram[512];

  typedef struct packed {
    logic [8:0] a;
    logic [7:0] d;
  } push_t;
  push_t wq[$];
  push_t mon_e;
  bit    we_seen;
  bit    mreq_seen;

  int unsigned g_delay_max = 0;
  int unsigned cur_delay   = 0;
  int unsigned wait_cnt    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Core-side RAM with one registered-read cycle.
  always @(posedge clk) sd_buff_din <= core_ram[sd_buff_addr];

  // Backing store: acks delay+1 cycles after seeing mem_req, new random delay per access.
  initial mem_ack = 1'b0;
  always @(posedge clk) begin
    if (mem_ack) begin
      mem_ack  <= 1'b0;
      wait_cnt <= 0;
    end else if (mem_req) begin
      if (wait_cnt >= cur_delay) begin
        mem_ack  <= 1'b1;
        wait_cnt <= 0;
        if (mem_we) store[mem_addr] = mem_wdata;
        else        mem_rdata <= store[mem_addr];
        cur_delay <= $urandom_range(g_delay_max, 0);
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      wait_cnt <= 0;
    end
  end

  always @(negedge clk) begin
    if (sd_buff_wr) begin
      mon_e.a = sd_buff_addr;
      mon_e.d = sd_buff_dout;
      wq.push_back(mon_e);
    end
    if (mem_req && mem_we) we_seen = 1'b1;
    if (mem_req) mreq_seen = 1'b1;
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Issues one request and follows it to sd_ack falling. Works from IDLE or from DONE (chained).
  task automatic do_sector(input bit rd, input bit wr, input logic [31:0] lba, input bit settle,
                           output int lat, output int len, output int rise_c, output int fall_c);
    bit prev_busy;
    bit latched;
    wq.delete();
    we_seen   = 1'b0;
    mreq_seen = 1'b0;
    sd_lba    = lba;
    sd_rd     = rd;
    sd_wr     = wr;
    prev_busy = busy;
    latched   = 1'b0;
    lat = -1; len = -1; rise_c = 0; fall_c = 0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      if (latched) lat++;
      else if (!prev_busy && busy) begin
        latched = 1'b1;
        lat     = 0;
      end
      prev_busy = busy;
      if (latched && sd_ack) break;
    end
    sd_rd = 1'b0;
    sd_wr = 1'b0;
    if (!(latched && sd_ack)) begin
      lat = -1;
      return;
    end
    rise_c = cyc;
    len    = 0;
    for (int n = 0; n < 10000; n++) begin
      @(posedge clk); #1;
      len++;
      if (!sd_ack) break;
    end
    if (sd_ack) len = -1;
    fall_c = cyc;
    if (settle) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_read(input logic [7:0] lba_lo, input string tag);
    int bad;
    int base;
    bad  = 0;
    base = int'(lba_lo) * 512;
    check({tag, "_pulses"}, wq.size(), 512);
    for (int j = 0; j < wq.size() && j < 512; j++) begin
      if (wq[j].a != j[8:0] || wq[j].d != ref_mem[base + j]) bad++;
    end
    check({tag, "_data"}, bad, 0);
  endtask

  task automatic check_store(input logic [7:0] lba_lo, input string tag);
    int bad;
    int base;
    bad  = 0;
    base = int'(lba_lo) * 512;
    for (int j = 0; j < 512; j++) begin
      if (store[base + j] != ref_mem[base + j]) bad++;
    end
    check({tag, "_store"}, bad, 0);
  endtask

  task automatic commit_write(input logic [7:0] lba_lo);
    for (int j = 0; j < 512; j++) ref_mem[int'(lba_lo) * 512 + j] = core_ram[j];
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] lba;
    logic [7:0]  seed;
    int          exp_len;
    int          exp_cnt;
  } vec_t;
  vec_t vecs[7];

  initial begin
    int lat, len, rc, fc, prev_fall, bad, found;
    logic [7:0] lo;

    vecs[0] = '{1'b1, 1'b0, 32'd3,          8'h00, 1536, 1};
    vecs[1] = '{1'b0, 1'b1, 32'd2,          8'h00, 2048, 2};
    vecs[2] = '{1'b1, 1'b1, 32'd7,          8'h00, 1536, 3};
    vecs[3] = '{1'b1, 1'b0, 32'd2,          8'h00, 1536, 4};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0103,  8'h00, 1536, 5};
    vecs[5] = '{1'b0, 1'b1, 32'hFFFF_FF05,  8'h40, 2048, 6};
    vecs[6] = '{1'b1, 1'b0, 32'd5,          8'h00, 1536, 7};

    RESET_n = 1'b0;
    sd_rd   = 1'b0;
    sd_wr   = 1'b0;
    sd_lba  = '0;
`ifdef SD_RESP_WRPROT_EN
    wr_prot = 1'b0;
`endif
    for (int a = 0; a < STORE_BYTES; a++) begin
      store[a]   = a[7:0] ^ a[16:9];
      ref_mem[a] = a[7:0] ^ a[16:9];
    end
    for (int j = 0; j < 512; j++) core_ram[j] = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    check("rst_sd_ack", sd_ack, 0);
    check("rst_buff_wr", sd_buff_wr, 0);
    check("rst_buff_addr", sd_buff_addr, 0);
    check("rst_buff_dout", sd_buff_dout, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_sect_cnt", sect_cnt, 0);
    RESET_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven single sectors with immediate store acks, so pulse lengths are exact.
    g_delay_max = 0;
    for (int i = 0; i < 7; i++) begin
      vec_t v;
      bit   is_write;
      v        = vecs[i];
      is_write = v.wr && !v.rd;
      lo       = v.lba[7:0];
      if (is_write) begin
        for (int j = 0; j < 512; j++) core_ram[j] = 8'hA5 + v.seed + 8'(j);
      end
      do_sector(v.rd, v.wr, v.lba, 1'b1, lat, len, rc, fc);
      check($sformatf("v%0d_latency", i), lat, SDLY + 1);
      check($sformatf("v%0d_ack_len", i), len, v.exp_len);
      check($sformatf("v%0d_sect_cnt", i), sect_cnt, v.exp_cnt);
      check($sformatf("v%0d_idle", i), busy, 0);
      if (is_write) begin
        commit_write(lo);
        check_store(lo, $sformatf("v%0d", i));
      end else begin
        check_read(lo, $sformatf("v%0d", i));
        check($sformatf("v%0d_no_we", i), we_seen, 0);
      end
    end

    // Reset in the middle of a write, at byte 200.
    for (int j = 0; j < 512; j++) core_ram[j] = 8'(j * 7);
    sd_lba = 32'd9;
    sd_wr  = 1'b1;
    found  = 0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      if (sd_ack) begin
        found = 1;
        break;
      end
    end
    sd_wr = 1'b0;
    check("rst_mid_ack_rise", found, 1);
    found = 0;
    for (int n = 0; n < 5000; n++) begin
      @(posedge clk); #1;
      if (sd_buff_addr == 9'd200 && mem_req) begin
        found = 1;
        break;
      end
    end
    check("rst_mid_reach_200", found, 1);
    RESET_n = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_sd_ack", sd_ack, 0);
    check("rst_mid_mem_req", mem_req, 0);
    check("rst_mid_sect_cnt", sect_cnt, 0);
    check("rst_mid_busy", busy, 0);
    RESET_n = 1'b1;
    @(posedge clk); #1;
    do_sector(1'b1, 1'b0, 32'd4, 1'b1, lat, len, rc, fc);
    check("rst_after_latency", lat, SDLY + 1);
    check_read(8'd4, "rst_after");
    check("rst_after_sect_cnt", sect_cnt, 1);

    // Back-to-back save-state chain with random store delay and random core data.
    RESET_n = 1'b0;
    @(posedge clk); #1;
    RESET_n = 1'b1;
    @(posedge clk); #1;
    g_delay_max = 3;
    prev_fall   = 0;
    for (int k = 0; k < 12; k++) begin
      for (int j = 0; j < 512; j++) core_ram[j] = 8'($urandom);
      do_sector(1'b0, 1'b1, k, (k == 11), lat, len, rc, fc);
      check($sformatf("chain%0d_latency", k), lat, SDLY + 1);
      if (k > 0) check($sformatf("chain%0d_gap_ok", k), int'((rc - prev_fall) >= SDLY + 1), 1);
      prev_fall = fc;
      lo = 8'(k);
      commit_write(lo);
      check_store(lo, $sformatf("chain%0d", k));
    end
    check("chain_sect_cnt", sect_cnt, 12);

    for (int k = 0; k < 2; k++) begin
      lo = 8'($urandom_range(11, 0));
      do_sector(1'b1, 1'b0, {24'h00AB00, lo}, 1'b1, lat, len, rc, fc);
      check_read(lo, $sformatf("readback%0d", k));
      check($sformatf("readback%0d_no_we", k), we_seen, 0);
    end

`ifdef SD_RESP_WRPROT_EN
    g_delay_max = 0;
    wr_prot     = 1'b1;
    for (int j = 0; j < 512; j++) core_ram[j] = 8'($urandom);
    do_sector(1'b0, 1'b1, 32'd1, 1'b1, lat, len, rc, fc);
    wr_prot = 1'b0;
    check("wp_latency", lat, SDLY + 1);
    check("wp_no_mem_req", mreq_seen, 0);
    check("wp_hit", wp_hit, 1);
    check_store(8'd1, "wp");
`endif

    // Whole store against the reference, except the sector aborted by reset.
    bad = 0;
    for (int a = 0; a < STORE_BYTES; a++) begin
      if (a / 512 != 9 && store[a] != ref_mem[a]) bad++;
    end
    check("final_store", bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
